// File: rtl/cla32_pipe_stage_if.sv
// Operand/result bus for cla32_pipe_stage: upstream operand beat and
// downstream result beat, each with its own valid/ready pair.
interface cla32_pipe_stage_if;
   // Valid/ready: a beat moves on a rising edge where valid && ready are both 1.
   // The sender holds valid and payload stable until that edge. Ready may
   // depend on the receiver's state but never on the sender's valid.
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        c_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s;
   logic        c_out;
   logic        ovf;
   logic        zero;

   modport master (
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, s, c_out, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, s, c_out, ovf, zero
   );
endinterface

// File: rtl/cla32_pipe_stage.sv
// Two-stage pipelined 32-bit carry-lookahead adder with valid/ready flow control.
// Stage 1 adds the low 16 bits, stage 2 the high 16 bits plus the flags.
module cla32_pipe_stage #(
   parameter int SPLIT = 16
) (
   input logic               clk,
   input logic               rst,
   cla32_pipe_stage_if.slave bus
);

   // 16-bit adder: 4-bit groups with full lookahead inside each group and a
   // group-level generate/propagate chain between groups. Returns {carry, sum}.
   function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci);
      logic [15:0] g;
      logic [15:0] p;
      logic [3:0]  gg;
      logic [3:0]  gp;
      logic [4:0]  gc;
      logic [15:0] c;
      g     = x & y;
      p     = x ^ y;
      gc[0] = ci;
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      end
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
      return {gc[4], p ^ c};
   endfunction

   logic                v1;
   logic                v2;
   logic [SPLIT-1:0]    s_lo_q;
   logic                c16_q;
   logic [31-SPLIT:0]   a_hi_q;
   logic [31-SPLIT:0]   b_hi_q;
   logic [31:0]         s_q;
   logic                c_out_q;
   logic                ovf_q;
   logic                zero_q;

   logic                adv1;
   logic                adv2;
   logic [16:0]         lo_sum;
   logic [16:0]         hi_sum;
   logic [31:0]         s_full;

   assign adv2 = !v2 || bus.out_ready;
   assign adv1 = !v1 || adv2;

   assign lo_sum = cla16(bus.a[SPLIT-1:0], bus.b[SPLIT-1:0], bus.c_in);
   assign hi_sum = cla16(a_hi_q, b_hi_q, c16_q);
   assign s_full = {hi_sum[15:0], s_lo_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         s_lo_q  <= '0;
         c16_q   <= 1'b0;
         a_hi_q  <= '0;
         b_hi_q  <= '0;
         s_q     <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         if (adv2) begin
            v2 <= v1;
            if (v1) begin
               s_q     <= s_full;
               c_out_q <= hi_sum[16];
               // Operand sign bits are the top bits of the stored high halves.
               ovf_q   <= (a_hi_q[15] == b_hi_q[15]) && (s_full[31] != a_hi_q[15]);
               zero_q  <= (s_full == 32'd0);
            end
         end
         if (adv1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
               s_lo_q <= lo_sum[15:0];
               c16_q  <= lo_sum[16];
               a_hi_q <= bus.a[31:SPLIT];
               b_hi_q <= bus.b[31:SPLIT];
            end
         end
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = v2;
   assign bus.s         = s_q;
   assign bus.c_out     = c_out_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla32_pipe_stage.sv
// Directed bench for cla32_pipe_stage: table of operand/result vectors plus
// hand-written latency, back-pressure, full-pipe and mid-flight reset sequences.
module tb_cla32_pipe_stage;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        c_in;
      logic [31:0] s;
      logic        c_out;
      logic        ovf;
      logic        zero;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   passes;
   int   cyc;
   logic [34:0] exp_q[$];
   int          pop_cyc[$];
   logic        hold_v;
   logic [34:0] held;

   cla32_pipe_stage_if bus ();

   cla32_pipe_stage #(.SPLIT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [34:0] rec(input logic c, input logic o, input logic z,
                                       input logic [31:0] s);
      return {c, o, z, s};
   endfunction

   // driver tasks
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic [34:0] e);
      logic acc;
      int   n;
      bus.a = x;
      bus.b = y;
      bus.c_in = ci;
      bus.in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      if (acc) exp_q.push_back(e);
      else check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // scoreboard / monitor
   always @(negedge clk) begin
      logic [34:0] cur;
      logic [34:0] e;
      cur = {bus.c_out, bus.ovf, bus.zero, bus.s};
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v && bus.out_valid) check("hold_stable", 64'(cur), 64'(held));
         hold_v = bus.out_valid && !bus.out_ready;
         held   = cur;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               check("result", 64'(cur), 64'(e));
            end
            pop_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      vec_t tbl[8];
      tbl[0] = '{32'd1000000,  32'd1231233,  1'b1, 32'd2231234,  1'b0, 1'b0, 1'b0};
      tbl[1] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      tbl[5] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};

      checks = 0;
      passes = 0;
      cyc = 0;
      hold_v = 1'b0;
      held = '0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.c_in = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_flags", 64'({bus.c_out, bus.ovf, bus.zero, bus.s}), 64'd0);
      @(posedge clk);
      #1;

      // single beat latency
      send(32'd1200, 32'd9999, 1'b0, rec(1'b0, 1'b0, 1'b0, 32'h00002BBF));
      @(negedge clk);
      check("lat_cycle1_idle", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
      check("lat_cycle2_s", 64'(bus.s), 64'd11199);
      @(negedge clk);
      check("lat_cycle3_idle", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      drain();

      // table vectors back to back at full throughput
      pop_cyc.delete();
      foreach (tbl[i])
         send(tbl[i].a, tbl[i].b, tbl[i].c_in,
              rec(tbl[i].c_out, tbl[i].ovf, tbl[i].zero, tbl[i].s));
      drain();
      check("b2b_count", 64'(pop_cyc.size()), 64'd8);
      for (int i = 1; i < pop_cyc.size(); i++)
         check("b2b_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

      // back-pressure: three beats with the consumer stalled
      bus.out_ready = 1'b0;
      send(32'd1, 32'd2, 1'b0, rec(1'b0, 1'b0, 1'b0, 32'd3));
      send(32'h80000000, 32'hFFFFFFFF, 1'b0, rec(1'b1, 1'b1, 1'b0, 32'h7FFFFFFF));
      bus.a = 32'h00FF00FF;
      bus.b = 32'h00010001;
      bus.c_in = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(32'h00FF00FF, 32'h00010001, 1'b1, rec(1'b0, 1'b0, 1'b0, 32'h01000101));
      drain();

      // full pipe with simultaneous emit and accept
      bus.out_ready = 1'b0;
      send(32'd10, 32'd20, 1'b0, rec(1'b0, 1'b0, 1'b0, 32'd30));
      send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, rec(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF));
      @(negedge clk);
      check("full_in_ready_low", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      bus.a = 32'd5;
      bus.b = 32'd5;
      bus.c_in = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("simul_in_ready", 64'(bus.in_ready), 64'd1);
      check("simul_out_valid", 64'(bus.out_valid), 64'd1);
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 32'd11));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("simul_after_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      drain();

      // reset with two beats in flight
      bus.out_ready = 1'b0;
      send(32'd3, 32'd4, 1'b0, rec(1'b0, 1'b0, 1'b0, 32'd7));
      send(32'd5, 32'd6, 1'b0, rec(1'b0, 1'b0, 1'b0, 32'd11));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
         if (i == 0) begin
            check("rst_mid_s", 64'(bus.s), 64'd0);
            check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
         end
      end
      @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
